fig_plot: RTL and testbench

- Downstream consumer of the figure-ring point stream.
- Accepts one HSV point per req/ack transaction, converts the colour to RGB565 with a multi-cycle integer pipeline, and clips against the framebuffer bounds.
- Issues one framebuffer pixel write per in-bounds point, then acknowledges the point.
- Sits between the figure ring and the framebuffer/LCD write port.

---
 rtl/fig_plot.sv | 212 +++++++++++++++++++++
 tb/tb_fig_plot.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fig_plot.sv
// Purpose: HSV point -> RGB565 pixel writer with framebuffer clipping, fed by the figure ring.
// Latency: fb_req_o rises 4 edges after fig_req_i is sampled; fig_ack_o follows fb_ack_i by one edge.
// Backpressure: holds fb_req_o/addr/data until fb_ack_i; no new point is taken until fig_req_i drops.
module fig_plot #(
   parameter int unsigned FB_WIDTH  = 240,
   parameter int unsigned FB_HEIGHT = 320,
   parameter int unsigned FB_AW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       fig_x_i,
   input  logic [8:0]       fig_y_i,
   input  logic [7:0]       fig_h_i,
   input  logic [7:0]       fig_s_i,
   input  logic [7:0]       fig_v_i,
   input  logic             fig_req_i,
   output logic             fig_ack_o,
   output logic [FB_AW-1:0] fb_addr_o,
   output logic [15:0]      fb_data_o,
   output logic             fb_req_o,
   input  logic             fb_ack_i
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SECTOR,
      ST_FRAC,
      ST_CHAN,
      ST_PACK,
      ST_WRITE,
      ST_ACK,
      ST_RELEASE
   } state_t;

   state_t state_q, state_d;

   // Captured point and pipeline stage registers
   logic [7:0] x_q;
   logic [8:0] y_q;
   logic [7:0] h_q, s_q, v_q;
   logic [2:0] region_q;
   logic [7:0] rem_q;
   logic [7:0] p_q, sa_q, sb_q;
   logic [7:0] q_q, t_q;

   // Combinational results feeding the registers
   logic [2:0]       region_d;
   logic [7:0]       base_d;
   logic [7:0]       rem_d;
   logic [7:0]       r_c, g_c, b_c;
   logic [15:0]      pix_data;
   logic [FB_AW-1:0] pix_addr;
   logic             in_bounds;
   logic             fig_ack_d, fb_req_d;
   logic [FB_AW-1:0] fb_addr_d;
   logic [15:0]      fb_data_d;

   // Upper byte of an 8x8 product, i.e. (a*b) >> 8 on a 16-bit product
   function automatic logic [7:0] mul_hi(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'd0, a} * {8'd0, b};
      return prod[15:8];
   endfunction

   // Hue sector (h/43) via range compares, and scaled position within the sector
   always_comb begin
      region_d = 3'd5;
      base_d   = 8'd215;
      if (h_q < 8'd43) begin
         region_d = 3'd0;
         base_d   = 8'd0;
      end else if (h_q < 8'd86) begin
         region_d = 3'd1;
         base_d   = 8'd43;
      end else if (h_q < 8'd129) begin
         region_d = 3'd2;
         base_d   = 8'd86;
      end else if (h_q < 8'd172) begin
         region_d = 3'd3;
         base_d   = 8'd129;
      end else if (h_q < 8'd215) begin
         region_d = 3'd4;
         base_d   = 8'd172;
      end
      // Offset within a sector is at most 42, so *6 stays within 8 bits
      rem_d = (h_q - base_d) * 8'd6;
   end

   // Channel selection by sector, grey override when saturation is zero, RGB565 packing
   always_comb begin
      r_c = v_q;
      g_c = p_q;
      b_c = q_q;
      if (s_q == 8'd0) begin
         r_c = v_q;
         g_c = v_q;
         b_c = v_q;
      end else begin
         case (region_q)
            3'd0:    begin r_c = v_q; g_c = t_q; b_c = p_q; end
            3'd1:    begin r_c = q_q; g_c = v_q; b_c = p_q; end
            3'd2:    begin r_c = p_q; g_c = v_q; b_c = t_q; end
            3'd3:    begin r_c = p_q; g_c = q_q; b_c = v_q; end
            3'd4:    begin r_c = t_q; g_c = p_q; b_c = v_q; end
            default: begin r_c = v_q; g_c = p_q; b_c = q_q; end
         endcase
      end
      pix_data  = {r_c[7:3], g_c[7:2], b_c[7:3]};
      pix_addr  = FB_AW'(y_q) * FB_AW'(FB_WIDTH) + FB_AW'(x_q);
      in_bounds = (32'(x_q) < FB_WIDTH) && (32'(y_q) < FB_HEIGHT);
   end

   // Datapath: capture the point once, then advance one arithmetic stage per state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         h_q      <= '0;
         s_q      <= '0;
         v_q      <= '0;
         region_q <= '0;
         rem_q    <= '0;
         p_q      <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         q_q      <= '0;
         t_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fig_req_i) begin
                  x_q <= fig_x_i;
                  y_q <= fig_y_i;
                  h_q <= fig_h_i;
                  s_q <= fig_s_i;
                  v_q <= fig_v_i;
               end
            end
            ST_SECTOR: begin
               region_q <= region_d;
               rem_q    <= rem_d;
            end
            ST_FRAC: begin
               p_q  <= mul_hi(v_q, 8'd255 - s_q);
               sa_q <= mul_hi(s_q, rem_q);
               sb_q <= mul_hi(s_q, 8'd255 - rem_q);
            end
            ST_CHAN: begin
               q_q <= mul_hi(v_q, 8'd255 - sa_q);
               t_q <= mul_hi(v_q, 8'd255 - sb_q);
            end
            default: ;
         endcase
      end
   end

   // Next-state and next-output logic; outputs are registered so they never glitch
   always_comb begin
      state_d   = state_q;
      fig_ack_d = 1'b0;
      fb_req_d  = fb_req_o;
      fb_addr_d = fb_addr_o;
      fb_data_d = fb_data_o;
      case (state_q)
         ST_IDLE:   if (fig_req_i) state_d = ST_SECTOR;
         ST_SECTOR: state_d = ST_FRAC;
         ST_FRAC:   state_d = ST_CHAN;
         ST_CHAN:   state_d = ST_PACK;
         ST_PACK: begin
            if (in_bounds) begin
               fb_addr_d = pix_addr;
               fb_data_d = pix_data;
               fb_req_d  = 1'b1;
               state_d   = ST_WRITE;
            end else begin
               // Clipped points are acknowledged without touching the framebuffer
               fig_ack_d = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_WRITE: begin
            if (fb_ack_i) begin
               fb_req_d  = 1'b0;
               fig_ack_d = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_ACK:     state_d = ST_RELEASE;
         // Wait for the upstream to drop req so a held req cannot trigger a second write
         ST_RELEASE: if (!fig_req_i) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset abandons any pending write silently
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         fig_ack_o <= 1'b0;
         fb_req_o  <= 1'b0;
         fb_addr_o <= '0;
         fb_data_o <= '0;
      end else begin
         state_q   <= state_d;
         fig_ack_o <= fig_ack_d;
         fb_req_o  <= fb_req_d;
         fb_addr_o <= fb_addr_d;
         fb_data_o <= fb_data_d;
      end
   end

endmodule

// File: tb/tb_fig_plot.sv
// Purpose: directed self-checking bench for fig_plot (colour, clipping, backpressure, handshake, reset).
// Latency: observes edge counts relative to the edge that samples fig_req_i.
// Backpressure: fb_ack_i is driven with a programmable delay after fb_req_o rises.
module tb_fig_plot;

   localparam int FB_AW = 17;

   logic             clock;
   logic             reset;
   logic [7:0]       fig_x_i;
   logic [8:0]       fig_y_i;
   logic [7:0]       fig_h_i;
   logic [7:0]       fig_s_i;
   logic [7:0]       fig_v_i;
   logic             fig_req_i;
   logic             fig_ack_o;
   logic [FB_AW-1:0] fb_addr_o;
   logic [15:0]      fb_data_o;
   logic             fb_req_o;
   logic             fb_ack_i;

   int checks = 0;
   int errors = 0;

   // Observations gathered by send_point
   int          obs_writes;
   int          obs_acks;
   int          obs_req_edge;
   int          obs_ack_edge;
   int          obs_unstable;
   logic [16:0] obs_addr;
   logic [15:0] obs_data;

   fig_plot dut (
      .clock     (clock),
      .reset     (reset),
      .fig_x_i   (fig_x_i),
      .fig_y_i   (fig_y_i),
      .fig_h_i   (fig_h_i),
      .fig_s_i   (fig_s_i),
      .fig_v_i   (fig_v_i),
      .fig_req_i (fig_req_i),
      .fig_ack_o (fig_ack_o),
      .fb_addr_o (fb_addr_o),
      .fb_data_o (fb_data_o),
      .fb_req_o  (fb_req_o),
      .fb_ack_i  (fb_ack_i)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Present one point and run a fixed 40-cycle window, recording what the DUT does.
   // Edge index k=0 is the edge that samples fig_req_i in idle.
   task automatic send_point(input logic [7:0] x, input logic [8:0] y, input logic [7:0] h,
                             input logic [7:0] s, input logic [7:0] v,
                             input int ack_delay, input int hold);
      int   hi_cnt;
      int   rel_cnt;
      bit   acked;
      logic prev_req;
      obs_writes   = 0;
      obs_acks     = 0;
      obs_req_edge = -1;
      obs_ack_edge = -1;
      obs_unstable = 0;
      obs_addr     = '0;
      obs_data     = '0;
      hi_cnt       = 0;
      rel_cnt      = 0;
      acked        = 0;
      prev_req     = 1'b0;
      fig_x_i   = x;
      fig_y_i   = y;
      fig_h_i   = h;
      fig_s_i   = s;
      fig_v_i   = v;
      fig_req_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         fb_ack_i = 1'b0;
         if (fb_req_o && !prev_req) begin
            obs_writes++;
            if (obs_req_edge < 0) obs_req_edge = k;
            obs_addr = fb_addr_o;
            obs_data = fb_data_o;
         end else if (fb_req_o && (fb_addr_o !== obs_addr || fb_data_o !== obs_data)) begin
            obs_unstable = 1;
         end
         prev_req = fb_req_o;
         if (fig_ack_o) begin
            obs_acks++;
            if (obs_ack_edge < 0) obs_ack_edge = k;
            acked = 1;
         end
         if (fb_req_o) begin
            if (hi_cnt == ack_delay) fb_ack_i = 1'b1;
            hi_cnt++;
         end
         if (acked) begin
            if (rel_cnt == hold) fig_req_i = 1'b0;
            rel_cnt++;
         end
      end
      fig_req_i = 1'b0;
      fb_ack_i  = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      fig_x_i   = '0;
      fig_y_i   = '0;
      fig_h_i   = '0;
      fig_s_i   = '0;
      fig_v_i   = '0;
      fig_req_i = 1'b0;
      fb_ack_i  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({fig_ack_o, fb_req_o, fb_addr_o, fb_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b req=%b addr=%0d data=%h, required all zero",
                  fig_ack_o, fb_req_o, fb_addr_o, fb_data_o);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_red();
      send_point(8'd10, 9'd20, 8'd0, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_req_edge !== 4) begin
         errors++;
         $display("FAIL red_latency: fb_req edge %0d, required 4", obs_req_edge);
      end
      checks++;
      if (obs_addr !== 17'd4810) begin
         errors++;
         $display("FAIL red_addr: got %0d, required 4810", obs_addr);
      end
      checks++;
      if (obs_data !== 16'hF800) begin
         errors++;
         $display("FAIL red_data: got %h, required f800", obs_data);
      end
      checks++;
      if (obs_acks !== 1 || obs_ack_edge !== 5) begin
         errors++;
         $display("FAIL red_ack: %0d pulses at edge %0d, required 1 at edge 5", obs_acks, obs_ack_edge);
      end
      checks++;
      if (obs_writes !== 1) begin
         errors++;
         $display("FAIL red_writes: got %0d, required 1", obs_writes);
      end
   endtask

   task automatic test_green();
      send_point(8'd1, 9'd0, 8'd85, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_data !== 16'h07E0 || obs_addr !== 17'd1) begin
         errors++;
         $display("FAIL green_pixel: data %h addr %0d, required 07e0 addr 1", obs_data, obs_addr);
      end
   endtask

   task automatic test_grey();
      send_point(8'd0, 9'd0, 8'd200, 8'd0, 8'd128, 0, 0);
      checks++;
      if (obs_data !== 16'h8410 || obs_addr !== 17'd0) begin
         errors++;
         $display("FAIL grey_pixel: data %h addr %0d, required 8410 addr 0", obs_data, obs_addr);
      end
   endtask

   task automatic test_clip();
      send_point(8'd250, 9'd5, 8'd0, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_writes !== 0) begin
         errors++;
         $display("FAIL clip_x_nowrite: %0d writes, required 0", obs_writes);
      end
      checks++;
      if (obs_acks !== 1 || obs_ack_edge !== 4) begin
         errors++;
         $display("FAIL clip_x_ack: %0d pulses at edge %0d, required 1 at edge 4", obs_acks, obs_ack_edge);
      end
      send_point(8'd0, 9'd320, 8'd0, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_writes !== 0) begin
         errors++;
         $display("FAIL clip_y_nowrite: %0d writes, required 0", obs_writes);
      end
      checks++;
      if (obs_acks !== 1 || obs_ack_edge !== 4) begin
         errors++;
         $display("FAIL clip_y_ack: %0d pulses at edge %0d, required 1 at edge 4", obs_acks, obs_ack_edge);
      end
      // Last pixel of the framebuffer, blue sector: region 3, rem 246 -> (0,9,255)
      send_point(8'd239, 9'd319, 8'd170, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_writes !== 1 || obs_addr !== 17'd76799) begin
         errors++;
         $display("FAIL clip_corner_addr: %0d writes addr %0d, required 1 write addr 76799",
                  obs_writes, obs_addr);
      end
      checks++;
      if (obs_data !== 16'h005F) begin
         errors++;
         $display("FAIL clip_corner_data: got %h, required 005f", obs_data);
      end
   endtask

   task automatic test_backpressure();
      // Region 4, rem 168 -> (168,0,255)
      send_point(8'd100, 9'd200, 8'd200, 8'd255, 8'd255, 6, 0);
      checks++;
      if (obs_unstable !== 0) begin
         errors++;
         $display("FAIL bp_stable: write changed while pending (flag %0d), required stable", obs_unstable);
      end
      checks++;
      if (obs_addr !== 17'd48100 || obs_data !== 16'hA81F) begin
         errors++;
         $display("FAIL bp_pixel: addr %0d data %h, required 48100 a81f", obs_addr, obs_data);
      end
      checks++;
      if (obs_acks !== 1 || obs_ack_edge !== 11) begin
         errors++;
         $display("FAIL bp_ack: %0d pulses at edge %0d, required 1 at edge 11", obs_acks, obs_ack_edge);
      end
      checks++;
      if (obs_writes !== 1) begin
         errors++;
         $display("FAIL bp_writes: got %0d, required 1", obs_writes);
      end
   endtask

   task automatic test_back_to_back();
      // Request held 3 cycles past the ack must not produce another write
      send_point(8'd10, 9'd20, 8'd0, 8'd255, 8'd255, 0, 3);
      checks++;
      if (obs_writes !== 1 || obs_acks !== 1) begin
         errors++;
         $display("FAIL held_req: %0d writes %0d acks, required 1 and 1", obs_writes, obs_acks);
      end
      // A fresh request after the drop is served normally
      send_point(8'd1, 9'd0, 8'd85, 8'd255, 8'd255, 0, 0);
      checks++;
      if (obs_writes !== 1 || obs_req_edge !== 4 || obs_data !== 16'h07E0) begin
         errors++;
         $display("FAIL rerequest: %0d writes edge %0d data %h, required 1 edge 4 data 07e0",
                  obs_writes, obs_req_edge, obs_data);
      end
   endtask

   task automatic test_reset_mid_write();
      int waited;
      int acks_seen;
      fig_x_i   = 8'd10;
      fig_y_i   = 9'd20;
      fig_h_i   = 8'd0;
      fig_s_i   = 8'd255;
      fig_v_i   = 8'd255;
      fig_req_i = 1'b1;
      fb_ack_i  = 1'b0;
      waited    = 0;
      while (!fb_req_o && waited < 20) begin
         @(posedge clock);
         #1;
         waited++;
      end
      checks++;
      if (!fb_req_o) begin
         errors++;
         $display("FAIL rst_reach_write: fb_req %b after %0d cycles, required 1", fb_req_o, waited);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({fig_ack_o, fb_req_o, fb_addr_o, fb_data_o} !== '0) begin
         errors++;
         $display("FAIL rst_async: ack=%b req=%b addr=%0d data=%h, required all zero",
                  fig_ack_o, fb_req_o, fb_addr_o, fb_data_o);
      end
      fig_req_i = 1'b0;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      fb_ack_i  = 1'b1;
      acks_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         #1;
         if (fig_ack_o || fb_req_o) acks_seen++;
      end
      fb_ack_i = 1'b0;
      checks++;
      if (acks_seen !== 0) begin
         errors++;
         $display("FAIL rst_no_ack: %0d cycles of ack/req activity, required 0", acks_seen);
      end
      // Idle after reset: a new point follows the normal timing
      send_point(8'd0, 9'd0, 8'd200, 8'd0, 8'd128, 0, 0);
      checks++;
      if (obs_req_edge !== 4 || obs_data !== 16'h8410 || obs_acks !== 1) begin
         errors++;
         $display("FAIL rst_recover: edge %0d data %h acks %0d, required 4 8410 1",
                  obs_req_edge, obs_data, obs_acks);
      end
   endtask

   initial begin
      test_reset();
      test_red();
      test_green();
      test_grey();
      test_clip();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
